apb_master_2s: RTL and testbench

APB requester driving the two-slave APB segment (slave1 and slave2) from a simple valid/ready command port.
- Decodes PADDR[7] to choose the slave.
- Sequences IDLE -> SETUP -> ACCESS and waits on the selected slave's PREADY.
- Returns read data, or an error if the slave stalls past a timeout.
- Sits between the on-chip control logic (or testbench driver) and the slave1/slave2 instances.

---
 rtl/apb_master_2s.sv | 179 +++++++++++++++++
 tb/tb_apb_master_2s.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_2s.sv
// APB requester for a two-slave segment: valid/ready command in,
// one-cycle response pulse out, PADDR[7] picks slave1 or slave2.
//
// Ports:
//   PCLK, PRESETn            clock, async active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata     command payload
//   rsp_valid/rdata/err      completion pulse, read data, timeout flag
//   PSEL1/PSEL2/PENABLE      APB control
//   PWRITE/PADDR/PWDATA      APB address/data phase
//   PRDATA1/2, PREADY1/2     per-slave read data and ready
module apb_master_2s #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA1,
    input  logic [7:0] PRDATA2,
    input  logic       PREADY1,
    input  logic       PREADY2
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       psel1_q, psel1_d;
    logic       psel2_q, psel2_d;
    logic       penable_q, penable_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q, rsp_err_d;

    logic       accept;
    logic       sel_ready;
    logic [7:0] sel_rdata;
    logic       timeout_hit;

    assign cmd_ready = (state_q == IDLE) && PRESETn;
    assign accept    = cmd_valid && cmd_ready;

    // Only the slave addressed by PADDR[7] is listened to.
    assign sel_ready = paddr_q[7] ? PREADY2 : PREADY1;
    assign sel_rdata = paddr_q[7] ? PRDATA2 : PRDATA1;

    // This wait edge would bring the counter to TIMEOUT.
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (sel_ready || timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel1_d     = psel1_q;
        psel2_d     = psel2_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                psel1_d   = 1'b0;
                psel2_d   = 1'b0;
                penable_d = 1'b0;
                if (accept) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    psel1_d  = ~cmd_addr[7];
                    psel2_d  = cmd_addr[7];
                end
            end
            SETUP: penable_d = 1'b1;
            ACCESS: begin
                if (sel_ready) begin
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? 8'h00 : sel_rdata;
                end else if (timeout_hit) begin
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 8'h00;
                end
            end
            default: begin
                psel1_d   = 1'b0;
                psel2_d   = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    assign PSEL1     = psel1_q;
    assign PSEL2     = psel2_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_2s.sv
// Directed bench for apb_master_2s: write, read, wait states,
// timeout, back-to-back commands and reset during ACCESS.
module tb_apb_master_2s;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL1;
    logic       PSEL2;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA1;
    logic [7:0] PRDATA2;
    logic       PREADY1;
    logic       PREADY2;

    int errors = 0;
    int checks = 0;

    apb_master_2s #(.TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL1     (PSEL1),
        .PSEL2     (PSEL2),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA1   (PRDATA1),
        .PRDATA2   (PRDATA2),
        .PREADY1   (PREADY1),
        .PREADY2   (PREADY2)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " psel1"}, 32'(PSEL1), 0);
        chk({tag, " psel2"}, 32'(PSEL2), 0);
        chk({tag, " penable"}, 32'(PENABLE), 0);
        chk({tag, " pwrite"}, 32'(PWRITE), 0);
        chk({tag, " paddr"}, 32'(PADDR), 0);
        chk({tag, " pwdata"}, 32'(PWDATA), 0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 0);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 0);
    endtask

    task automatic issue(input logic w, input logic [7:0] a,
                         input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        int pen_cycles;
        bit done;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        PRDATA1   = 8'h00;
        PRDATA2   = 8'h00;
        PREADY1   = 1'b0;
        PREADY2   = 1'b0;

        #2;
        all_zero("reset");
        tick();
        tick();
        PRESETn = 1'b1;
        #1;
        chk("rdy after reset", 32'(cmd_ready), 1);

        // write slave1, zero wait
        issue(1'b1, 8'h05, 8'hA5);
        PREADY1 = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("wr setup psel1", 32'(PSEL1), 1);
        chk("wr setup psel2", 32'(PSEL2), 0);
        chk("wr setup pen", 32'(PENABLE), 0);
        chk("wr paddr", 32'(PADDR), 32'h05);
        chk("wr pwdata", 32'(PWDATA), 32'hA5);
        chk("wr pwrite", 32'(PWRITE), 1);
        chk("wr setup rdy", 32'(cmd_ready), 0);
        tick();
        chk("wr acc psel1", 32'(PSEL1), 1);
        chk("wr acc pen", 32'(PENABLE), 1);
        chk("wr acc rv", 32'(rsp_valid), 0);
        tick();
        chk("wr rsp_valid", 32'(rsp_valid), 1);
        chk("wr rsp_err", 32'(rsp_err), 0);
        chk("wr rsp_rdata", 32'(rsp_rdata), 0);
        chk("wr done psel1", 32'(PSEL1), 0);
        chk("wr done pen", 32'(PENABLE), 0);
        chk("wr done rdy", 32'(cmd_ready), 1);
        tick();
        chk("wr rv drop", 32'(rsp_valid), 0);
        chk("wr paddr hold", 32'(PADDR), 32'h05);

        // read slave2, slave1 signals must be ignored
        PREADY1 = 1'b0;
        PRDATA1 = 8'hEE;
        PREADY2 = 1'b1;
        PRDATA2 = 8'h3C;
        issue(1'b0, 8'h85, 8'h00);
        tick();
        cmd_valid = 1'b0;
        chk("rd2 psel1", 32'(PSEL1), 0);
        chk("rd2 psel2", 32'(PSEL2), 1);
        chk("rd2 pwrite", 32'(PWRITE), 0);
        tick();
        chk("rd2 pen", 32'(PENABLE), 1);
        tick();
        chk("rd2 rv", 32'(rsp_valid), 1);
        chk("rd2 rdata", 32'(rsp_rdata), 32'h3C);
        chk("rd2 err", 32'(rsp_err), 0);
        chk("rd2 psel2 off", 32'(PSEL2), 0);
        tick();
        chk("rd2 rdata hold", 32'(rsp_rdata), 32'h3C);

        // read slave1 with three wait states
        PREADY2 = 1'b0;
        PREADY1 = 1'b0;
        PRDATA1 = 8'h77;
        issue(1'b0, 8'h10, 8'h00);
        tick();
        cmd_valid = 1'b0;
        pen_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) PREADY1 = 1'b1;
            pen_cycles += int'(PENABLE);
            chk("ws paddr", 32'(PADDR), 32'h10);
            chk("ws psel1", 32'(PSEL1), 1);
            chk("ws rv", 32'(rsp_valid), 0);
        end
        chk("ws pen cycles", 32'(pen_cycles), 4);
        tick();
        chk("ws rv", 32'(rsp_valid), 1);
        chk("ws rdata", 32'(rsp_rdata), 32'h77);
        chk("ws err", 32'(rsp_err), 0);
        tick();

        // timeout on slave1
        PREADY1 = 1'b0;
        issue(1'b0, 8'h20, 8'h00);
        tick();
        cmd_valid = 1'b0;
        pen_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (rsp_valid) done = 1'b1;
            else pen_cycles += int'(PENABLE);
        end
        chk("to seen", 32'(done), 1);
        chk("to pen cycles", 32'(pen_cycles), 16);
        chk("to err", 32'(rsp_err), 1);
        chk("to rdata", 32'(rsp_rdata), 0);
        chk("to rdy", 32'(cmd_ready), 1);
        chk("to pen off", 32'(PENABLE), 0);
        tick();
        chk("to rv drop", 32'(rsp_valid), 0);
        chk("to err hold", 32'(rsp_err), 1);

        // back-to-back: write 0x02, then read 0x82
        PREADY1 = 1'b1;
        PREADY2 = 1'b1;
        PRDATA2 = 8'h99;
        issue(1'b1, 8'h02, 8'h5A);
        tick();
        issue(1'b0, 8'h82, 8'h00);
        chk("b2b1 psel1", 32'(PSEL1), 1);
        tick();
        chk("b2b1 excl", 32'(PSEL1 & PSEL2), 0);
        chk("b2b1 paddr", 32'(PADDR), 32'h02);
        tick();
        chk("b2b1 rv", 32'(rsp_valid), 1);
        chk("b2b1 rdy", 32'(cmd_ready), 1);
        chk("b2b1 err", 32'(rsp_err), 0);
        tick();
        cmd_valid = 1'b0;
        chk("b2b2 psel2", 32'(PSEL2), 1);
        chk("b2b2 excl", 32'(PSEL1 & PSEL2), 0);
        chk("b2b2 paddr", 32'(PADDR), 32'h82);
        chk("b2b2 rv drop", 32'(rsp_valid), 0);
        tick();
        chk("b2b2 pen", 32'(PENABLE), 1);
        tick();
        chk("b2b2 rv", 32'(rsp_valid), 1);
        chk("b2b2 rdata", 32'(rsp_rdata), 32'h99);
        tick();

        // reset during ACCESS
        PREADY1 = 1'b0;
        issue(1'b0, 8'h01, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst pre pen", 32'(PENABLE), 1);
        #2;
        PRESETn = 1'b0;
        #1;
        all_zero("rst mid");
        PREADY1 = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid) done = 1'b1;
        end
        chk("rst no rv", 32'(done), 0);
        PRESETn = 1'b1;
        #1;
        PREADY2 = 1'b1;
        issue(1'b1, 8'h83, 8'h11);
        tick();
        cmd_valid = 1'b0;
        chk("post psel2", 32'(PSEL2), 1);
        chk("post paddr", 32'(PADDR), 32'h83);
        chk("post pwdata", 32'(PWDATA), 32'h11);
        tick();
        tick();
        chk("post rv", 32'(rsp_valid), 1);
        chk("post err", 32'(rsp_err), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
